// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared opcodes and add/subtract result function
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the shared function handles; callers zero-extend into it.
    localparam int MAX_W = 32;

    // Returns {ovf, c}: ovf in the top bit, c zero-extended to MAX_W+1 bits.
    // Only the low width+1 bits of c are meaningful.
    function automatic logic [MAX_W+1:0] calc_result(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             op,
        input logic             sat,
        input int               width
    );
        logic [MAX_W:0] s;
        logic [MAX_W:0] mask_c;
        logic [MAX_W:0] mask_v;
        logic [MAX_W:0] c;
        logic           msb;
        logic           ovf;
        // mask_c keeps width+1 bits (result incl. carry/borrow), mask_v keeps width bits
        mask_c = {(MAX_W+1){1'b1}} >> (MAX_W - width);
        mask_v = mask_c >> 1;
        if (op == OP_SUB) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, b};
        end
        s   = s & mask_c;
        // Bit 'width' of the raw result: carry for ADD, borrow for SUB
        msb = |(s & ~mask_v);
        if (!sat) begin
            c   = s;
            ovf = msb;
        end else if (msb) begin
            c   = (op == OP_SUB) ? '0 : mask_v;
            ovf = 1'b1;
        end else begin
            c   = s & mask_v;
            ovf = 1'b0;
        end
        return {ovf, c};
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - one valid/ready register slice of the adder pipeline
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int DW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Slice can take new data when empty or when its current contents leave this cycle
    assign up_ready = !valid_q || dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    // Load on upstream transfer; clear when upstream has nothing while we drain; hold otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined add/subtract unit with valid/ready handshake
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STAGES   = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   c,
    output logic             ovf
);

    // Payload carried down the pipe: {ovf, c}
    localparam int DW = WIDTH + 2;

    logic [MAX_W+1:0] res;
    logic [DW-1:0]    calc_data;

    // Chain links: index i is the upstream side of stage i, index STAGES is the output
    logic             v_link    [STAGES+1];
    logic             rdy_link  [STAGES+1];
    logic [DW-1:0]    data_link [STAGES+1];

    assign res       = calc_result(MAX_W'(a), MAX_W'(b), op, SATURATE != 0, WIDTH);
    assign calc_data = {res[MAX_W+1], res[WIDTH:0]};

    generate
        if (WIDTH < MAX_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = &{1'b0, res[MAX_W:WIDTH+1]};
        end
    endgenerate

    assign v_link[0]         = in_valid;
    assign data_link[0]      = calc_data;
    assign rdy_link[STAGES]  = out_ready;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            adder_pipe_stage #(
                .DW(DW)
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .up_valid (v_link[i]),
                .up_ready (rdy_link[i]),
                .up_data  (data_link[i]),
                .dn_valid (v_link[i+1]),
                .dn_ready (rdy_link[i+1]),
                .dn_data  (data_link[i+1])
            );
        end
    endgenerate

    assign in_ready  = rdy_link[0];
    assign out_valid = v_link[STAGES];
    assign c         = data_link[STAGES][WIDTH:0];
    assign ovf       = data_link[STAGES][WIDTH+1];

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - directed and scoreboarded bench for adder_pipe
module tb_adder_pipe;
    import adder_pkg::*;

    localparam int ST   [4] = '{2, 2, 1, 4};
    localparam bit SATD [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       op = OP_ADD;
    logic [3:0] a = '0;
    logic [3:0] b = '0;

    logic       ir    [4];
    logic       ov    [4];
    logic       ovf_o [4];
    logic [4:0] c_o   [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(4), .STAGES(2), .SATURATE(0)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .op(op),
        .out_valid(ov[0]), .out_ready(out_ready), .c(c_o[0]), .ovf(ovf_o[0]));
    adder_pipe #(.WIDTH(4), .STAGES(2), .SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .op(op),
        .out_valid(ov[1]), .out_ready(out_ready), .c(c_o[1]), .ovf(ovf_o[1]));
    adder_pipe #(.WIDTH(4), .STAGES(1), .SATURATE(0)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .op(op),
        .out_valid(ov[2]), .out_ready(out_ready), .c(c_o[2]), .ovf(ovf_o[2]));
    adder_pipe #(.WIDTH(4), .STAGES(4), .SATURATE(0)) u3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b), .op(op),
        .out_valid(ov[3]), .out_ready(out_ready), .c(c_o[3]), .ovf(ovf_o[3]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       op;
        logic [4:0] c0;
        logic       v0;
        logic [4:0] c1;
        logic       v1;
    } vec_t;

    vec_t vecs [9];

    // Scoreboard for the random stream: expected {ovf, c} per DUT
    logic [5:0] exp_mem [4][64];
    int         wp [4];
    int         rp [4];
    logic       prev_ov  [4];
    logic [5:0] prev_dat [4];
    logic       prev_or;

    task automatic rnd_cycle(input bit drain);
        logic [33:0] r;
        @(negedge clk);
        in_valid  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
        out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        a  = 4'($urandom);
        b  = 4'($urandom);
        op = 1'($urandom);
        #1;
        for (int d = 0; d < 4; d++) begin
            if (prev_ov[d] && !prev_or) begin
                chk("stall_hold_valid", 32'(ov[d]), 32'd1);
                chk("stall_hold_data", 32'({ovf_o[d], c_o[d]}), 32'(prev_dat[d]));
            end
            if (ov[d] && out_ready) begin
                if (rp[d] == wp[d]) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    chk("rnd_result", 32'({ovf_o[d], c_o[d]}), 32'(exp_mem[d][rp[d] % 64]));
                    rp[d]++;
                end
            end
            if (in_valid && ir[d]) begin
                r = calc_result(MAX_W'(a), MAX_W'(b), op, SATD[d], 4);
                exp_mem[d][wp[d] % 64] = {r[33], r[4:0]};
                wp[d]++;
            end
            prev_ov[d]  = ov[d];
            prev_dat[d] = {ovf_o[d], c_o[d]};
        end
        prev_or = out_ready;
    endtask

    initial begin
        int acc;
        int got_q [$];

        vecs[0] = '{4'd3,  4'd2, OP_ADD, 5'h05, 1'b0, 5'h05, 1'b0};
        vecs[1] = '{4'd15, 4'd1, OP_ADD, 5'h10, 1'b1, 5'h0F, 1'b1};
        vecs[2] = '{4'd2,  4'd5, OP_SUB, 5'h1D, 1'b1, 5'h00, 1'b1};
        vecs[3] = '{4'd12, 4'd9, OP_ADD, 5'h15, 1'b1, 5'h0F, 1'b1};
        vecs[4] = '{4'd9,  4'd4, OP_SUB, 5'h05, 1'b0, 5'h05, 1'b0};
        vecs[5] = '{4'd0,  4'd0, OP_SUB, 5'h00, 1'b0, 5'h00, 1'b0};
        vecs[6] = '{4'd15, 4'd15, OP_ADD, 5'h1E, 1'b1, 5'h0F, 1'b1};
        vecs[7] = '{4'd15, 4'd0, OP_SUB, 5'h0F, 1'b0, 5'h0F, 1'b0};
        vecs[8] = '{4'd0,  4'd1, OP_SUB, 5'h1F, 1'b1, 5'h00, 1'b1};

        // Reset state while reset is held from time zero
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("reset_out_valid", 32'(ov[d]), 32'd0);
            chk("reset_c", 32'(c_o[d]), 32'd0);
            chk("reset_ovf", 32'(ovf_o[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) chk("reset_in_ready", 32'(ir[d]), 32'd1);

        // Single-op vectors through the 2-stage units, latency exactly 2
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("vec_early", 32'(ov[0]), 32'd0);
            @(negedge clk);
            #1;
            chk("vec_valid0", 32'(ov[0]), 32'd1);
            chk("vec_c0", 32'(c_o[0]), 32'(vecs[i].c0));
            chk("vec_ovf0", 32'(ovf_o[0]), 32'(vecs[i].v0));
            chk("vec_valid1", 32'(ov[1]), 32'd1);
            chk("vec_c1", 32'(c_o[1]), 32'(vecs[i].c1));
            chk("vec_ovf1", 32'(ovf_o[1]), 32'(vecs[i].v1));
            @(negedge clk);
            #1;
            chk("vec_one_cycle", 32'(ov[0]), 32'd0);
        end

        // Backpressure on u0: two accepts fill it, then in_ready drops and c=1 holds
        out_ready = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            a = acc[3:0]; b = 4'd1; op = OP_ADD; in_valid = 1'b1;
            #1;
            if (cyc >= 2) begin
                chk("bp_hold_valid", 32'(ov[0]), 32'd1);
                chk("bp_hold_c", 32'(c_o[0]), 32'd1);
            end
            if (ir[0]) acc++;
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        chk("bp_in_ready_low", 32'(ir[0]), 32'd0);
        for (int cyc = 0; cyc < 40 && got_q.size() < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (acc < 8);
            a = acc[3:0];
            #1;
            if (ov[0]) got_q.push_back(int'(c_o[0]));
            if (in_valid && ir[0]) acc++;
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < got_q.size(); i++) chk("bp_order", 32'(got_q[i]), 32'(i + 1));

        // Reset mid-stream with ops in flight, then a fresh op per depth
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 4'd5; b = 4'd3; op = OP_ADD;
        @(negedge clk);
        a = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_mid_valid", 32'(ov[d]), 32'd0);
            chk("rst_mid_c", 32'(c_o[d]), 32'd0);
            chk("rst_mid_ovf", 32'(ovf_o[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) chk("rst_mid_in_ready", 32'(ir[d]), 32'd1);
        repeat (3) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 4; d++) chk("no_stale", 32'(ov[d]), 32'd0);
        end
        @(negedge clk);
        a = 4'd1; b = 4'd1; op = OP_ADD; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            for (int d = 0; d < 4; d++) begin
                if (d == 1) continue;
                chk("post_rst_latency", 32'(ov[d]), 32'(k == ST[d]));
                if (k == ST[d]) chk("post_rst_c", 32'(c_o[d]), 32'd2);
            end
            @(negedge clk);
        end

        // Random traffic with out_ready gaps, checked against calc_result
        for (int d = 0; d < 4; d++) begin
            wp[d] = 0; rp[d] = 0; prev_ov[d] = 1'b0; prev_dat[d] = '0;
        end
        prev_or = 1'b1;
        repeat (300) rnd_cycle(1'b0);
        repeat (12) rnd_cycle(1'b1);
        for (int d = 0; d < 4; d++) chk("rnd_drained", 32'(wp[d] - rp[d]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
